alu_seq: RTL

- Parametrised, multicycle successor of the 8-bit datapath ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus four flags (N, Z, V, C) on an output valid/ready handshake.
- Multiplication is an iterative shift-add; all other ops complete in one cycle.
- Sits between register-file read and writeback, so the core can stall on multiply without a combinational multiplier.

---
 rtl/alu_seq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : multicycle ALU with valid/ready handshakes on both sides.
//
// Takes one operation per input handshake. Single-cycle ops register their
// result in the cycle after acceptance. MUL runs an iterative shift-add,
// one multiplier bit per cycle, and presents its result WIDTH+1 cycles after
// acceptance. The result is held in DONE until the consumer takes it.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   op/a/b valid
//   o_in_ready   block can accept an operation (IDLE)
//   i_op         4-bit opcode
//   i_a, i_b     operands (b is also the shift amount)
//   o_out_valid  result/flags/illegal valid (DONE)
//   i_out_ready  consumer takes the result
//   o_result     WIDTH-bit result
//   o_flags      {N,Z,V,C}
//   o_illegal    captured opcode was unused
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags,
    output logic             o_illegal
);

    // Bits of b that can express a meaningful shift amount; anything above
    // them set means the shift clears the whole word.
    localparam int SHW = $clog2(WIDTH) + 1;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        K_ILL, K_ADD, K_SUB, K_MUL, K_AND, K_OR, K_XOR, K_LSL, K_LSR
    } kind_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_illegal;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_mul_last;
    kind_t              w_kind;
    logic [WIDTH-1:0]   w_res;
    logic               w_v;
    logic               w_c;
    logic               w_ill;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_b_hi_nz;
    logic [SHW-1:0]     w_sh_amt;
    logic [WIDTH:0]     w_lsl_ext;
    logic [WIDTH:0]     w_lsr_ext;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_prod_hi_nz;

    assign w_accept   = i_in_valid && (r_state == S_IDLE);
    assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (i_op == 4'b1010) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_in_ready  = (r_state == S_IDLE);
        o_out_valid = (r_state == S_DONE);
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        w_kind = K_ILL;
        case (i_op)
            4'b1000, 4'b0001: w_kind = K_ADD;
            4'b1001, 4'b0010: w_kind = K_SUB;
            4'b1010:          w_kind = K_MUL;
            4'b1011, 4'b0011: w_kind = K_AND;
            4'b1100, 4'b0100: w_kind = K_OR;
            4'b0101:          w_kind = K_XOR;
            4'b1101, 4'b0110: w_kind = K_LSL;
            4'b1111, 4'b0111: w_kind = K_LSR;
            default:          w_kind = K_ILL;
        endcase
    end

    // Carry out of bit WIDTH-1 lands in the extra top bit; for SUB it is
    // the no-borrow indication.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(1);

    // Shifts run on a one-bit-wider word so the last bit shifted out
    // falls into the extra bit and becomes C.
    assign w_b_hi_nz = |(i_b >> SHW);
    assign w_sh_amt  = i_b[SHW-1:0];
    assign w_lsl_ext = {1'b0, i_a} << w_sh_amt;
    assign w_lsr_ext = {i_a, 1'b0} >> w_sh_amt;

    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        w_ill = 1'b0;
        case (w_kind)
            K_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            K_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            K_AND: w_res = i_a & i_b;
            K_OR:  w_res = i_a | i_b;
            K_XOR: w_res = i_a ^ i_b;
            K_LSL: begin
                if (!w_b_hi_nz) begin
                    w_res = w_lsl_ext[WIDTH-1:0];
                    w_c   = w_lsl_ext[WIDTH];
                end
            end
            K_LSR: begin
                if (!w_b_hi_nz) begin
                    w_res = w_lsr_ext[WIDTH:1];
                    w_c   = w_lsr_ext[0];
                end
            end
            K_MUL: w_res = '0;
            default: w_ill = 1'b1;
        endcase
    end

    // ---------------- shift-add multiplier ----------------
    assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_result  <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_kind == K_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, i_a};
                            r_mplier <= i_b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_result  <= w_res;
                            r_flags   <= {w_res[WIDTH-1], (w_res == '0), w_v, w_c};
                            r_illegal <= w_ill;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_mul_last) begin
                        r_result  <= w_acc_next[WIDTH-1:0];
                        r_flags   <= {w_acc_next[WIDTH-1],
                                      (w_acc_next[WIDTH-1:0] == '0),
                                      w_prod_hi_nz, w_prod_hi_nz};
                        r_illegal <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result  = r_result;
    assign o_flags   = r_flags;
    assign o_illegal = r_illegal;

endmodule
